// File: rtl/hack_ctrl_pkg.sv
// Shared definitions for the Hack control sequencer: state codes, instruction
// field positions and the comp/jump encodings used to build instructions.
package hack_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_MREAD = 3'd2;
  localparam state_t ST_EXEC  = 3'd3;
  localparam state_t ST_PCUPD = 3'd4;

  localparam int CI      = 15;
  localparam int ABIT    = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JLT     = 2;
  localparam int JEQ     = 1;
  localparam int JGT     = 0;

  typedef logic [5:0] comp_t;
  typedef logic [2:0] jump_t;

  // X stands for A or M depending on the a-bit.
  localparam comp_t COMP_ZERO   = 6'b101010;
  localparam comp_t COMP_ONE    = 6'b111111;
  localparam comp_t COMP_NEG1   = 6'b111010;
  localparam comp_t COMP_D      = 6'b001100;
  localparam comp_t COMP_X      = 6'b110000;
  localparam comp_t COMP_D_M1   = 6'b001110;
  localparam comp_t COMP_X_P1   = 6'b110111;
  localparam comp_t COMP_D_PLUS = 6'b000010;

  localparam jump_t J_NONE = 3'b000;
  localparam jump_t J_GT   = 3'b001;
  localparam jump_t J_EQ   = 3'b010;
  localparam jump_t J_GE   = 3'b011;
  localparam jump_t J_LT   = 3'b100;
  localparam jump_t J_NE   = 3'b101;
  localparam jump_t J_LE   = 3'b110;
  localparam jump_t J_MP   = 3'b111;

  function automatic logic [15:0] c_instr(input logic a, input comp_t comp,
                                          input logic [2:0] dest, input jump_t jump);
    return {3'b111, a, comp, dest, jump};
  endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Jump condition evaluation from the instruction jump bits and the ALU flags.
module hack_jump_eval
  import hack_ctrl_pkg::*;
(
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       jmp
);

  assign jmp = (jump[JLT] & ng) | (jump[JEQ] & zr) | (jump[JGT] & ~ng & ~zr);

endmodule

// File: rtl/hack_ctrl_seq.sv
// Multi-cycle Hack instruction sequencer: fetch handshake, optional M read,
// execute with optional M write, then PC increment or jump.
module hack_ctrl_seq
  import hack_ctrl_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [width-1:0] instruction,
  output logic             zx,
  output logic             nx,
  output logic             zy,
  output logic             ny,
  output logic             f,
  output logic             no,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             sel_am,
  output logic             sel_a_src,
  output logic             load_a,
  output logic             load_d,
  output logic             m_rd_req,
  input  logic             m_rd_ack,
  output logic             m_wr_req,
  input  logic             m_wr_ack,
  output logic             pc_inc,
  output logic             pc_load
);

  state_t           state;
  state_t           state_nxt;
  logic [width-1:0] ir;
  logic             jmp_q;
  logic             jmp_now;
  logic             is_c;
  logic             busy;
  logic             exec_exit;
  logic             unused_ir_bits;

  assign is_c           = ir[CI];
  assign busy           = (state == ST_MREAD) || (state == ST_EXEC) || (state == ST_PCUPD);
  assign exec_exit      = !is_c || !ir[DEST_M] || m_wr_ack;
  assign unused_ir_bits = ^ir[14:13];

  hack_jump_eval u_jump_eval (
    .jump (ir[JLT:JGT]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .jmp  (jmp_now)
  );

  // ALU controls come straight from the held instruction, so they stay stable
  // for the whole execution and read as zero for A-instructions.
  assign {zx, nx, zy, ny, f, no} = (busy && is_c) ? ir[COMP_HI:COMP_LO] : 6'b0;
  assign sel_am                  = busy && is_c && ir[ABIT];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_nxt   = state;
    instr_ready = 1'b0;
    sel_a_src   = 1'b0;
    load_a      = 1'b0;
    load_d      = 1'b0;
    m_rd_req    = 1'b0;
    m_wr_req    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nxt = (instruction[CI] && instruction[ABIT]) ? ST_MREAD : ST_EXEC;
      end
      ST_MREAD: begin
        m_rd_req = 1'b1;
        if (m_rd_ack) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (!is_c) begin
          sel_a_src = 1'b1;
          load_a    = 1'b1;
          state_nxt = ST_PCUPD;
        end else begin
          m_wr_req = ir[DEST_M];
          if (exec_exit) begin
            load_a    = ir[DEST_A];
            load_d    = ir[DEST_D];
            state_nxt = ST_PCUPD;
          end
        end
      end
      ST_PCUPD: begin
        pc_load   = is_c && jmp_q;
        pc_inc    = !(is_c && jmp_q);
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ir    <= '0;
      jmp_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && instr_valid) ir <= instruction;
      // Flags are sampled only in the exit cycle, when the ALU result is final.
      if (state == ST_EXEC && exec_exit) jmp_q <= is_c && jmp_now;
    end
  end

endmodule

// File: tb/tb_hack_ctrl_seq.sv
// Self-checking bench for hack_ctrl_seq: per-cycle expected outputs are queued
// when an instruction's stimulus is planned and compared as the DUT runs.
module tb_hack_ctrl_seq;
  import hack_ctrl_pkg::*;

  typedef struct packed {
    logic       instr_ready;
    logic [5:0] ctrl;
    logic       sel_am;
    logic       sel_a_src;
    logic       load_a;
    logic       load_d;
    logic       m_rd_req;
    logic       m_wr_req;
    logic       pc_inc;
    logic       pc_load;
  } out_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] word;
    logic        rd_ack;
    logic        wr_ack;
    logic        zr;
    logic        ng;
    out_t        exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instruction = '0;
  logic        zx, nx, zy, ny, f, no;
  logic        alu_zr = 1'b0;
  logic        alu_ng = 1'b0;
  logic        sel_am, sel_a_src, load_a, load_d;
  logic        m_rd_req, m_wr_req, pc_inc, pc_load;
  logic        m_rd_ack = 1'b0;
  logic        m_wr_ack = 1'b0;
  out_t        obs;

  int   n_checks = 0;
  int   n_errors = 0;
  cyc_t sb_q[$];

  always #5 clk = ~clk;

  hack_ctrl_seq #(.width(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .zx          (zx),
    .nx          (nx),
    .zy          (zy),
    .ny          (ny),
    .f           (f),
    .no          (no),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .sel_am      (sel_am),
    .sel_a_src   (sel_a_src),
    .load_a      (load_a),
    .load_d      (load_d),
    .m_rd_req    (m_rd_req),
    .m_rd_ack    (m_rd_ack),
    .m_wr_req    (m_wr_req),
    .m_wr_ack    (m_wr_ack),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load)
  );

  assign obs = '{instr_ready: instr_ready, ctrl: {zx, nx, zy, ny, f, no},
                 sel_am: sel_am, sel_a_src: sel_a_src, load_a: load_a, load_d: load_d,
                 m_rd_req: m_rd_req, m_wr_req: m_wr_req, pc_inc: pc_inc, pc_load: pc_load};

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Plan one instruction from FETCH back to FETCH, then drain it cycle by cycle.
  task automatic run_instr(input string tag, input logic [15:0] instr, input int vdelay,
                           input int rd_lat, input int wr_lat, input logic zr, input logic ng);
    cyc_t c;
    out_t base;
    logic is_c;
    logic jmp;
    int   n;
    int   k;
    is_c = instr[15];
    for (int i = 0; i < vdelay; i++) begin
      // Stray acks while waiting for an instruction must be ignored.
      c = '0; c.word = ~instr; c.rd_ack = 1'b1; c.wr_ack = 1'b1;
      c.exp.instr_ready = 1'b1;
      sb_q.push_back(c);
    end
    c = '0; c.valid = 1'b1; c.word = instr; c.exp.instr_ready = 1'b1;
    sb_q.push_back(c);
    base        = '0;
    base.ctrl   = is_c ? instr[11:6] : 6'b0;
    base.sel_am = is_c & instr[12];
    if (is_c && instr[12]) begin
      for (int i = 0; i <= rd_lat; i++) begin
        c = '0; c.word = ~instr; c.rd_ack = (i == rd_lat); c.zr = ~zr; c.ng = ~ng;
        c.exp = base; c.exp.m_rd_req = 1'b1;
        sb_q.push_back(c);
      end
    end
    if (!is_c) begin
      c = '0; c.word = ~instr; c.wr_ack = 1'b1;
      c.exp = base; c.exp.sel_a_src = 1'b1; c.exp.load_a = 1'b1;
      sb_q.push_back(c);
    end else begin
      n = instr[3] ? wr_lat : 0;
      for (int i = 0; i <= n; i++) begin
        c = '0; c.word = ~instr;
        c.wr_ack = instr[3] && (i == n);
        c.zr = (i == n) ? zr : ~zr;
        c.ng = (i == n) ? ng : ~ng;
        c.exp = base; c.exp.m_wr_req = instr[3];
        c.exp.load_a = (i == n) && instr[5];
        c.exp.load_d = (i == n) && instr[4];
        sb_q.push_back(c);
      end
    end
    jmp = is_c && ((instr[2] && ng) || (instr[1] && zr) || (instr[0] && !ng && !zr));
    c = '0; c.word = ~instr; c.zr = ~zr; c.ng = ~ng;
    c.exp = base; c.exp.pc_load = jmp; c.exp.pc_inc = !jmp;
    sb_q.push_back(c);

    k = 0;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      instr_valid = c.valid; instruction = c.word;
      m_rd_ack = c.rd_ack; m_wr_ack = c.wr_ack;
      alu_zr = c.zr; alu_ng = c.ng;
      #1;
      check($sformatf("%s cyc%0d", tag, k), 32'(obs), 32'(c.exp));
      @(posedge clk); #1;
      k++;
    end
    instr_valid = 1'b0; m_rd_ack = 1'b0; m_wr_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    out_t e;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs), 32'h0);
    rst_n = 1'b1;
    #1;
    check("idle_after_release", 32'(obs), 32'h0);
    @(posedge clk); #1;

    run_instr("a_0005",       16'h0005, 0, 0, 0, 1'b0, 1'b0);
    run_instr("d_m_plus1",    16'hFDD0, 0, 2, 0, 1'b0, 1'b0);
    run_instr("m_eq_d",       16'hE308, 0, 0, 3, 1'b0, 1'b0);
    run_instr("jmp",          16'hEA87, 0, 0, 0, 1'b1, 1'b0);
    run_instr("jlt_ng",       16'hE304, 0, 0, 0, 1'b0, 1'b1);
    run_instr("jlt_zr",       16'hE304, 0, 0, 0, 1'b1, 1'b0);
    run_instr("jgt_zr",       16'hE301, 0, 0, 0, 1'b1, 1'b0);
    run_instr("jgt_pos",      16'hE301, 0, 0, 0, 1'b0, 1'b0);
    run_instr("jeq_zr",       c_instr(1'b0, COMP_D, 3'b000, J_EQ), 0, 0, 0, 1'b1, 1'b0);
    run_instr("amd_d_m1",     16'hE3B8, 4, 0, 1, 1'b0, 1'b0);
    run_instr("am_m_plus1",   c_instr(1'b1, COMP_X_P1, 3'b101, J_NONE), 1, 0, 0, 1'b0, 1'b1);

    // Reset asserted mid-transaction while a memory read is outstanding.
    instr_valid = 1'b1; instruction = 16'hFDD0;
    #1;
    e = '0; e.instr_ready = 1'b1;
    check("rst_accept", 32'(obs), 32'(e));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    #1;
    e = '0; e.ctrl = 6'b110111; e.sel_am = 1'b1; e.m_rd_req = 1'b1;
    check("rst_in_mread", 32'(obs), 32'(e));
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", 32'(obs), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_idle_cycle", 32'(obs), 32'h0);
    @(posedge clk); #1;
    run_instr("a_after_rst",  16'h0005, 0, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hack_ctrl_seq.md
Name: hack_ctrl_seq

Overview:
- Multi-cycle Hack instruction sequencer; the control-side end of the ALU interface.
- Accepts one 16-bit instruction per valid/ready handshake.
- Drives the six ALU control bits and the datapath selects/loads.
- Consumes the ALU zr/ng flags to decide jumps, and sequences data-memory read/write handshakes and PC update.

Parameters:
- width, 16, instruction/datapath word width; instruction field positions fixed for width=16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction word available
- instr_ready  out  1  sequencer accepts instruction this cycle
- instruction  in  width  Hack instruction
- zx, nx, zy, ny, f, no  out  1 each  ALU control
- alu_zr, alu_ng  in  1 each  ALU flags
- sel_am  out  1  ALU y operand: 0=A, 1=M
- sel_a_src  out  1  A-register source: 1=instruction, 0=ALU out
- load_a, load_d  out  1 each  register write strobes, one-cycle pulse
- m_rd_req  out  1  data-memory read request; datapath latches M on ack
- m_rd_ack  in  1  read complete
- m_wr_req  out  1  data-memory write of ALU out to address A
- m_wr_ack  in  1  write complete
- pc_inc, pc_load  out  1 each  PC strobes, one-cycle pulse, mutually exclusive

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE. Any rst_n assertion, including mid-transaction, aborts immediately; pending requests are dropped.
- States: IDLE, FETCH, MREAD, EXEC, PCUPD.
- IDLE: first clk edge with rst_n high -> FETCH.
- FETCH:
  - instr_ready=1; ALU/datapath controls 0.
  - On instr_valid&instr_ready, latch instruction as ir.
  - Next state: MREAD if ir[15]&ir[12], else EXEC.
  - instr_valid low -> hold FETCH.
- From the cycle after accept until return to FETCH:
  - {zx,nx,zy,ny,f,no}=ir[11:6] and sel_am=ir[12] when ir[15]=1; all 0 for A-instructions.
  - Values are held stable throughout.
- MREAD: m_rd_req=1 until the cycle m_rd_ack=1, then EXEC. No timeout.
- EXEC, A-instruction (ir[15]=0):
  - One cycle: sel_a_src=1, load_a=1, then PCUPD.
- EXEC, C-instruction:
  - sel_a_src=0.
  - If ir[3] (dest M): m_wr_req=1, hold EXEC until m_wr_ack.
  - The exit cycle is the ack cycle, or the first EXEC cycle if there is no M dest.
  - In the exit cycle: load_a=ir[5], load_d=ir[4], and latch jmp = (ir[2]&alu_ng) | (ir[1]&alu_zr) | (ir[0]&~alu_ng&~alu_zr).
  - All destinations therefore receive the same ALU result computed from pre-instruction A/D/M.
- PCUPD: one cycle; pc_load=jmp (C-instruction only), else pc_inc=1; then FETCH.
- Minimum occupancy:
  - A-instruction or C-instruction without M: 3 cycles (FETCH, EXEC, PCUPD).
  - Each MREAD or M-write wait adds ack latency.
- Acks arriving outside their request are ignored.
- ir[14:13] are ignored.

Decomposition:
- Package hack_ctrl_pkg:
  - state enum;
  - bit positions CI=15, ABIT=12, COMP=11:6, DEST_A=5, DEST_D=4, DEST_M=3, JLT=2, JEQ=1, JGT=0;
  - comp/jump code constants for benches.
- Sub-module hack_jump_eval: combinational (ir[2:0], zr, ng) -> jmp.

Test Plan:
- Reset: pull rst_n low while in MREAD with m_rd_req=1 -> all outputs 0 same cycle; after release, IDLE for 1 cycle, then instr_ready=1.
- A-instruction 0x0005 accepted -> next cycle load_a=1, sel_a_src=1, ALU ctrl 0; next cycle pc_inc=1; next cycle instr_ready=1.
- D=M+1 (0xFDD0), m_rd_ack after 2 cycles -> m_rd_req held 3 cycles; then EXEC with ctrl=110111, sel_am=1, load_d pulse; then pc_inc.
- M=D (0xE308), m_wr_ack after 3 cycles -> ctrl=001100 stable across all EXEC cycles; m_wr_req held until ack; load_a=load_d=0; then pc_inc.
- Jumps:
  - 0;JMP 0xEA87 -> pc_load.
  - D;JLT 0xE304 with ng=1 -> pc_load; with zr=1, ng=0 -> pc_inc.
  - D;JGT 0xE301 with zr=1 -> pc_inc; with zr=0, ng=0 -> pc_load.
- AMD=D-1 (0xE3B8) with instr_valid withheld 4 cycles -> FETCH holds, controls 0; after accept, m_wr_req; on ack cycle load_a and load_d pulse together with sel_a_src=0.
